// File: rtl/vga_pkg.sv
// Shared constants and types for the obstacle controller.
//   X_START    : off-screen column an obstacle sweep starts from
//   SPEED      : pixels moved per frame tick
//   OBST_WIDTH : obstacle column width in pixels
//   GAP        : vertical opening between the top and bottom obstacles
//   GAP_MIN    : smallest top-obstacle extent
//   state_t    : obstacle FSM states
package vga_pkg;

  localparam logic [11:0] X_START    = 12'd800;
  localparam logic [11:0] SPEED      = 12'd2;
  localparam logic [11:0] OBST_WIDTH = 12'd50;
  localparam logic [11:0] GAP        = 12'd150;
  localparam logic [11:0] GAP_MIN    = 12'd100;
  localparam logic [11:0] TOP_RESET  = 12'd200;
  localparam logic [11:0] BOT_RESET  = 12'd350;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Galois mask for the x^16 + x^14 + x^13 + x^11 + 1 polynomial
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length Galois LFSR (right-shifting).
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, loads LFSR_SEED
//   value : current LFSR state, never zero
module lfsr16
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/obstacle_ctrl.sv
// Obstacle column controller: sweeps an obstacle pair right-to-left once
// per frame tick, re-randomises the gap on wrap and counts obstacles the
// bird has passed.
// Ports:
//   clk               : pixel clock
//   rst               : asynchronous active-high reset
//   vblnk             : vertical blanking, rising edge is the frame tick
//   start             : one-cycle start / restart request
//   game_over         : collision level from game logic
//   bird_xpos         : bird sprite left edge
//   obstacle_xpos     : obstacle column left edge (registered)
//   obstacle_ypos_top : last row of the top obstacle (registered)
//   obstacle_ypos_bot : first row of the bottom obstacle (registered)
//   score_pulse       : one-cycle pulse per obstacle passed
//   score             : saturating count of obstacles passed
//   running           : high while the FSM is in RUN
module obstacle_ctrl
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic        game_over,
  input  logic [11:0] bird_xpos,
  output logic [11:0] obstacle_xpos,
  output logic [11:0] obstacle_ypos_top,
  output logic [11:0] obstacle_ypos_bot,
  output logic        score_pulse,
  output logic [7:0]  score,
  output logic        running
);

  state_t      state;
  logic        vblnk_d;
  logic        tick;
  logic [15:0] lfsr;
  logic        unused_lfsr;

  logic [11:0] xpos_dec;
  logic [11:0] top_new;
  logic [11:0] bot_new;
  logic        wrap;
  logic        passed;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Only the low byte feeds the gap position.
  assign unused_lfsr = ^lfsr[15:8];

  assign tick     = vblnk & ~vblnk_d;
  assign xpos_dec = obstacle_xpos - SPEED;
  assign top_new  = GAP_MIN + {4'h0, lfsr[7:0]};
  assign bot_new  = top_new + GAP;
  // Reload before the subtraction could underflow.
  assign wrap     = (obstacle_xpos <= SPEED);
  // The right edge crosses the bird's left edge on this step.
  assign passed   = ((obstacle_xpos + OBST_WIDTH) > bird_xpos) &&
                    ((xpos_dec + OBST_WIDTH) <= bird_xpos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      obstacle_xpos     <= X_START;
      obstacle_ypos_top <= TOP_RESET;
      obstacle_ypos_bot <= BOT_RESET;
      score_pulse       <= 1'b0;
      score             <= 8'd0;
      running           <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          obstacle_xpos <= X_START;
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // Collision wins over a same-cycle start and freezes this frame.
          if (game_over) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (tick) begin
            if (wrap) begin
              obstacle_xpos     <= X_START;
              obstacle_ypos_top <= top_new;
              obstacle_ypos_bot <= bot_new;
            end else begin
              obstacle_xpos <= xpos_dec;
              if (passed) begin
                score_pulse <= 1'b1;
                score       <= sat_inc(score);
              end
            end
          end
        end
        STOP: begin
          if (start) begin
            state         <= IDLE;
            score         <= 8'd0;
            obstacle_xpos <= X_START;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_ctrl.sv
module tb_obstacle_ctrl;

  logic        clk;
  logic        rst;
  logic        vblnk;
  logic        start;
  logic        game_over;
  logic [11:0] bird_xpos;
  logic [11:0] obstacle_xpos;
  logic [11:0] obstacle_ypos_top;
  logic [11:0] obstacle_ypos_bot;
  logic        score_pulse;
  logic [7:0]  score;
  logic        running;

  int vectors;
  int errors;
  int pulse_cnt;

  // Reference LFSR: m is the state now, m_prev the state before the last edge.
  logic [15:0] m;
  logic [15:0] m_prev;
  logic [15:0] tick_lfsr;
  logic        tick_pulse;

  obstacle_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .vblnk             (vblnk),
    .start             (start),
    .game_over         (game_over),
    .bird_xpos         (bird_xpos),
    .obstacle_xpos     (obstacle_xpos),
    .obstacle_ypos_top (obstacle_ypos_top),
    .obstacle_ypos_bot (obstacle_ypos_bot),
    .score_pulse       (score_pulse),
    .score             (score),
    .running           (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m      <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m;
      m      <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(negedge clk) begin
    if (score_pulse) pulse_cnt++;
  end

  // One frame: vblnk rises, the tick edge is sampled, then vblnk falls.
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    @(posedge clk);
    #1;
    tick_lfsr  = m_prev;
    tick_pulse = score_pulse;
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL reset_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (obstacle_ypos_top !== 12'd200) begin errors++; $display("FAIL reset_top got %0d want 200", obstacle_ypos_top); end
    vectors++; if (obstacle_ypos_bot !== 12'd350) begin errors++; $display("FAIL reset_bot got %0d want 350", obstacle_ypos_bot); end
    vectors++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    vectors++; if (score_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", score_pulse); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    repeat (3) frame();
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL idle_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (obstacle_ypos_top !== 12'd200) begin errors++; $display("FAIL idle_top got %0d want 200", obstacle_ypos_top); end
    vectors++; if (obstacle_ypos_bot !== 12'd350) begin errors++; $display("FAIL idle_bot got %0d want 350", obstacle_ypos_bot); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running got %b want 0", running); end
  endtask

  task automatic test_run_score_wrap();
    logic [11:0] exp_top;
    bird_xpos = 12'd300;
    pulse_start();
    vectors++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
    repeat (10) frame();
    vectors++; if (obstacle_xpos !== 12'd780) begin errors++; $display("FAIL ten_ticks_xpos got %0d want 780", obstacle_xpos); end
    vectors++; if (score !== 8'd0) begin errors++; $display("FAIL ten_ticks_score got %0d want 0", score); end
    vectors++; if (running !== 1'b1) begin errors++; $display("FAIL ten_ticks_running got %b want 1", running); end

    for (int i = 0; i < 300; i++) begin
      frame();
      if (obstacle_xpos == 12'd250) break;
    end
    vectors++; if (obstacle_xpos !== 12'd250) begin errors++; $display("FAIL reach_250 got %0d want 250", obstacle_xpos); end
    vectors++; if (tick_pulse !== 1'b1) begin errors++; $display("FAIL pass_pulse got %b want 1", tick_pulse); end
    vectors++; if (score !== 8'd1) begin errors++; $display("FAIL pass_score got %0d want 1", score); end
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL pass_pulse_count got %0d want 1", pulse_cnt); end

    for (int i = 0; i < 200; i++) begin
      frame();
      if (obstacle_xpos == 12'd2) break;
    end
    vectors++; if (obstacle_xpos !== 12'd2) begin errors++; $display("FAIL reach_2 got %0d want 2", obstacle_xpos); end
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL sweep_pulse_count got %0d want 1", pulse_cnt); end

    frame();
    exp_top = 12'd100 + {4'h0, tick_lfsr[7:0]};
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL wrap_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (obstacle_ypos_top !== exp_top) begin errors++; $display("FAIL wrap_top got %0d want %0d", obstacle_ypos_top, exp_top); end
    vectors++; if (obstacle_ypos_bot !== exp_top + 12'd150) begin errors++; $display("FAIL wrap_bot got %0d want %0d", obstacle_ypos_bot, exp_top + 12'd150); end
    vectors++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", tick_pulse); end
    vectors++; if (score !== 8'd1) begin errors++; $display("FAIL wrap_score got %0d want 1", score); end
  endtask

  task automatic test_long_vblnk();
    @(negedge clk) vblnk = 1'b1;
    repeat (4) @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    vectors++; if (obstacle_xpos !== 12'd798) begin errors++; $display("FAIL long_vblnk_xpos got %0d want 798", obstacle_xpos); end
  endtask

  task automatic test_stop();
    @(negedge clk) begin game_over = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1;
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got %b want 0", running); end
    @(negedge clk) begin game_over = 1'b0; start = 1'b0; end
    repeat (5) frame();
    vectors++; if (obstacle_xpos !== 12'd798) begin errors++; $display("FAIL stop_frozen_xpos got %0d want 798", obstacle_xpos); end
    vectors++; if (score !== 8'd1) begin errors++; $display("FAIL stop_frozen_score got %0d want 1", score); end
    pulse_start();
    vectors++; if (score !== 8'd0) begin errors++; $display("FAIL restart_score got %0d want 0", score); end
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL restart_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL restart_running got %b want 0", running); end
    frame();
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL idle_after_stop_xpos got %0d want 800", obstacle_xpos); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (3) frame();
    vectors++; if (obstacle_xpos !== 12'd794) begin errors++; $display("FAIL prereset_xpos got %0d want 794", obstacle_xpos); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL areset_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (obstacle_ypos_top !== 12'd200) begin errors++; $display("FAIL areset_top got %0d want 200", obstacle_ypos_top); end
    vectors++; if (obstacle_ypos_bot !== 12'd350) begin errors++; $display("FAIL areset_bot got %0d want 350", obstacle_ypos_bot); end
    vectors++; if (score !== 8'd0) begin errors++; $display("FAIL areset_score got %0d want 0", score); end
    vectors++; if (score_pulse !== 1'b0) begin errors++; $display("FAIL areset_pulse got %b want 0", score_pulse); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running got %b want 0", running); end
    @(negedge clk) rst = 1'b0;
    frame();
    vectors++; if (obstacle_xpos !== 12'd800) begin errors++; $display("FAIL post_reset_tick_xpos got %0d want 800", obstacle_xpos); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL post_reset_running got %b want 0", running); end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    vblnk     = 1'b0;
    start     = 1'b0;
    game_over = 1'b0;
    bird_xpos = 12'd0;
    tick_lfsr = 16'h0;
    tick_pulse = 1'b0;
    test_reset();
    test_idle();
    test_run_score_wrap();
    test_long_vblnk();
    test_stop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
